cla_tap_accum: RTL and testbench
================================

Name: cla_tap_accum

Overview:
- Accumulator stage directly downstream of the Booth/CHT product path. It consumes one signed tap product per handshake and sums TAPS products into a wide accumulator.
- The adder is a carry-lookahead adder built from per-bit propagate/generate cells and 4-bit lookahead groups, matching the arithmetic style of the multiplier datapath.
- After TAPS products it emits one FIR output sample over a valid/ready handshake.

Parameters:
- IN_W, 16, width of signed product input.
- ACC_W, 36, accumulator/output width; must be >= IN_W and a multiple of 4.
- TAPS, 8, products summed per output sample; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  product available.
- in_ready  output  1  block accepts product this cycle.
- in_data  input  IN_W  signed two's-complement product.
- out_valid  output  1  accumulated sample available.
- out_ready  input  1  consumer accepts sample.
- out_data  output  ACC_W  signed accumulated sample.
- busy  output  1  high while a frame is partially accumulated or held.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset values: state=IDLE, acc=0, tap_cnt=0, out_valid=0, out_data=0, busy=0. in_ready is 1 after reset.
- Accept condition: in_valid && in_ready.
- Adder: acc_next = acc + sign_extend(in_data) mod 2^ACC_W, with carry-in 0.
  - Per-bit p = a^b, g = a&b.
  - Group P/G computed per 4-bit group; inter-group carries by ripple-of-lookahead.
  - Purely combinational within one cycle.
- FSM:
  - IDLE: acc=0, tap_cnt=0, in_ready=1. On accept: acc<=sext(in_data), tap_cnt<=1, go to ACCUM.
  - ACCUM: in_ready=1. On accept: acc<=acc_next, tap_cnt<=tap_cnt+1.
    - If this is the TAPS-th accept (tap_cnt==TAPS-1): out_data<=acc_next, out_valid<=1, go to HOLD.
    - No accept: hold all state, with no timeout.
  - HOLD: in_ready=0, out_valid=1, out_data stable. On out_ready: out_valid<=0, acc<=0, tap_cnt<=0, go to IDLE.
- Latency: out_valid rises the cycle after the TAPS-th accepted product.
- Throughput: one product per cycle. Each sample needs at least TAPS+1 cycles, because the HOLD cycle blocks input.
- busy = (state != IDLE).
- Boundaries:
  - Overflow wraps modulo 2^ACC_W, with no saturation.
  - out_ready while out_valid=0 is ignored.
  - in_valid in HOLD is not accepted; upstream must hold its data.
  - rst mid-frame or in HOLD discards the partial sum and the pending output; out_valid drops the next cycle.
  - tap_cnt width is clog2(TAPS) and never exceeds TAPS-1.

Optional Feature:
- Macro: CLA_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit).
  - A sticky per-frame flag sets when any addition in the frame overflows in the signed sense (carry into MSB XOR carry out of MSB).
  - ovf is registered alongside out_data, is valid while out_valid=1, and clears on rst or on the output handshake.
- Undefined: no ovf port and no overflow logic; behaviour is otherwise identical.

Decomposition:
- Package cla_pkg:
  - state enum {IDLE, ACCUM, HOLD}.
  - constant CLA_GRP_W=4.
  - function for group-carry computation from group P/G and carry-in.
- One sub-module, cla_group4: 4-bit lookahead group.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], group P, group G, and msb carry-in (for the CLA_OVF_EN overflow check).
  - Instantiated ACC_W/4 times in cla_tap_accum.

Test Plan:
- Basic sum: TAPS=8, in_data 1..8 back-to-back with out_ready=1 → out_data=36 one cycle after the 8th accept; out_valid high for 1 cycle; in_ready low for that cycle.
- Signed mix: inputs -5, 3, -100, 50, 0, 7, -1, 46 → out_data=0; then all eight = -32768 → out_data = -262144 (0xFFFFC0000 at ACC_W=36).
- Back-pressure: out_ready=0 for 5 cycles after the frame completes → out_valid and out_data stable, in_ready=0, offered in_valid ignored. Raise out_ready → next frame's first product is accepted in the cycle after the handshake.
- Input gaps: in_valid toggled 1-0-1 with random gaps → the same 36 result; tap_cnt advances only on accept.
- Reset mid-frame: rst after 4 of 8 products → next cycle busy=0, acc=0. A fresh frame of all 2s → out_data=16.
- Wrap and overflow (CLA_OVF_EN, IN_W=16, ACC_W=16): eight inputs of 0x7FFF → out_data=0xFFF8, ovf=1. Next frame of eight 1s → out_data=8, ovf=0.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the carry-lookahead tap accumulator.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int CLA_GRP_W = 4;

    // Carry out of a lookahead group from its group propagate/generate and carry-in.
    function automatic logic cla_group_carry(input logic grp_p, input logic grp_g, input logic cin);
        return grp_g | (grp_p & cin);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum bits, group propagate/generate and the carry into bit 3.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       grp_p,
    output logic       grp_g,
    output logic       msb_cin
);

    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [3:0] c_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // All internal carries are flattened lookahead terms, not a ripple.
    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & cin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin);

    assign s       = p_s ^ c_s;
    assign grp_p   = &p_s;
    assign grp_g   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                   | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    assign msb_cin = c_s[3];

endmodule

// File: rtl/cla_tap_accum.sv
// Sums TAPS signed products through a CLA adder and emits one sample per frame.
// Defining CLA_OVF_EN adds a sticky per-frame signed-overflow output (ovf).
module cla_tap_accum
    import cla_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int ACC_W = 36,
    parameter int TAPS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
`ifdef CLA_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NG    = ACC_W / CLA_GRP_W;
    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

    state_e            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_valid_q;
    logic [ACC_W-1:0]  out_data_q;
    logic              in_ready_q;
    logic              busy_q;

    logic [ACC_W-1:0]  b_s;
    logic [NG:0]       carry_s;
    logic [NG-1:0]     grp_p_s;
    logic [NG-1:0]     grp_g_s;
    logic [NG-1:0]     msb_cin_s;
    logic              accept_s;

    assign b_s        = ACC_W'($signed(in_data));
    assign accept_s   = in_valid & in_ready_q;
    assign carry_s[0] = 1'b0;

    // Group carries ripple from one lookahead group to the next.
    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group4 u_grp (
            .a       (acc_q[k*CLA_GRP_W +: CLA_GRP_W]),
            .b       (b_s[k*CLA_GRP_W +: CLA_GRP_W]),
            .cin     (carry_s[k]),
            .s       (acc_d[k*CLA_GRP_W +: CLA_GRP_W]),
            .grp_p   (grp_p_s[k]),
            .grp_g   (grp_g_s[k]),
            .msb_cin (msb_cin_s[k])
        );
        assign carry_s[k+1] = cla_group_carry(grp_p_s[k], grp_g_s[k], carry_s[k]);
    end

`ifdef CLA_OVF_EN
    logic ovf_s;
    logic ovf_frm_q;
    logic ovf_q;

    assign ovf_s = msb_cin_s[NG-1] ^ carry_s[NG];
    assign ovf   = ovf_q;

    // Sticky overflow tracking, latched into ovf alongside out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_frm_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        ovf_frm_q <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        ovf_frm_q <= ovf_frm_q | ovf_s;
                        if (cnt_q == LAST_CNT) begin
                            ovf_q <= ovf_frm_q | ovf_s;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        ovf_frm_q <= 1'b0;
                        ovf_q     <= 1'b0;
                    end
                end
                default: begin
                    ovf_frm_q <= 1'b0;
                    ovf_q     <= 1'b0;
                end
            endcase
        end
    end
`endif

    // Frame FSM: accumulate TAPS products, then hold the sample until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        acc_q   <= b_s;
                        cnt_q   <= CNT_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        acc_q <= acc_d;
                        if (cnt_q == LAST_CNT) begin
                            // Counter parks at zero so it never exceeds TAPS-1 in HOLD.
                            cnt_q       <= '0;
                            out_data_q  <= acc_d;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cla_tap_accum.sv
// Directed self-checking bench for cla_tap_accum (TAPS=8, IN_W=16).
module tb_cla_tap_accum;

`ifdef CLA_OVF_EN
    localparam int ACC_W = 16;
`else
    localparam int ACC_W = 36;
`endif
    localparam int IN_W = 16;
    localparam int TAPS = 8;
    localparam logic [63:0] MASK = (64'd1 << ACC_W) - 64'd1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             busy;
`ifdef CLA_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [IN_W-1:0] vec [0:7];

    cla_tap_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .TAPS(TAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef CLA_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] v);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            step();
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_vec(input int max_gap);
        for (int i = 0; i < TAPS; i++) begin
            send(vec[i]);
            if (max_gap > 0 && i < TAPS - 1) begin
                int gap = $urandom_range(max_gap, 0);
                for (int j = 0; j < gap; j++) step();
            end
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < TAPS; i++) vec[i] = IN_W'(v);
    endtask

    // Called right after the TAPS-th accept edge: sample must be presented.
    task automatic expect_out(input string tag, input logic [63:0] exp_data, input logic exp_ovf);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), exp_data & MASK);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
`ifdef CLA_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) check({tag, "_ovf_arg"}, 64'd0, 64'd1);
`endif
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_busy_drop"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Basic sum 1..8, back-to-back.
        for (int i = 0; i < TAPS; i++) vec[i] = IN_W'(i + 1);
        send_vec(0);
        expect_out("basic", 64'd36, 1'b0);
        drain("basic");
        check("basic_in_ready_back", 64'(in_ready), 64'd1);

        // Signed mix summing to zero.
        vec[0] = -16'sd5;  vec[1] = 16'sd3; vec[2] = -16'sd100; vec[3] = 16'sd50;
        vec[4] = 16'sd0;   vec[5] = 16'sd7; vec[6] = -16'sd1;   vec[7] = 16'sd46;
        send_vec(0);
        expect_out("mix", 64'd0, 1'b0);
        drain("mix");

        // Most negative product eight times.
        fill(-32768);
        send_vec(0);
        expect_out("neg", 64'hFFFF_FFFF_FFFC_0000, (ACC_W == 16) ? 1'b1 : 1'b0);
        drain("neg");

        // Back-pressure: sample holds, offered input ignored.
        out_ready = 1'b0;
        for (int i = 0; i < TAPS; i++) vec[i] = IN_W'(i + 1);
        send_vec(0);
        in_valid = 1'b1;
        in_data  = 16'd5;
        for (int c = 0; c < 5; c++) begin
            expect_out("bp", 64'd36, 1'b0);
            check("bp_busy", 64'(busy), 64'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_valid_drop", 64'(out_valid), 64'd0);
        check("bp_in_ready", 64'(in_ready), 64'd1);
        check("bp_idle", 64'(busy), 64'd0);
        step();
        check("bp_first_accept", 64'(busy), 64'd1);
        in_valid = 1'b0;
        fill(1);
        for (int i = 1; i < TAPS; i++) send(vec[i]);
        expect_out("bp_next", 64'd12, 1'b0);
        drain("bp_next");

        // Input gaps: same 1..8 result.
        for (int i = 0; i < TAPS; i++) vec[i] = IN_W'(i + 1);
        send_vec(3);
        expect_out("gaps", 64'd36, 1'b0);
        drain("gaps");

        // Reset mid-frame, then a fresh frame of 2s.
        for (int i = 0; i < 4; i++) send(16'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        fill(2);
        send_vec(0);
        expect_out("twos", 64'd16, 1'b0);
        drain("twos");

        // Reset while holding a sample.
        out_ready = 1'b0;
        fill(3);
        send_vec(0);
        expect_out("hold_pre", 64'd24, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("holdrst_valid", 64'(out_valid), 64'd0);
        check("holdrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        // Wrap: eight 0x7FFF, then eight 1s.
        fill(32767);
        send_vec(0);
        expect_out("wrap", 64'h3FFF8, (ACC_W == 16) ? 1'b1 : 1'b0);
        drain("wrap");
        fill(1);
        send_vec(0);
        expect_out("ones", 64'd8, 1'b0);
        drain("ones");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
